ppm_frame_sched: RTL and testbench

PPM_FRAME_SCHED -- requirements
Module: ppm_frame_sched

---
 rtl/ppm_pkg.sv | 18 +
 rtl/ppm_seg_timer.sv | 31 +++
 rtl/ppm_frame_sched.sv | 146 ++++++++++++++
 tb/tb_ppm_frame_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared PPM definitions: frame scheduler state encoding and default timing constants,
// used by the scheduler, the detector and the AXI register block.
package ppm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_CHAN,
        ST_TAIL_GAP,
        ST_SYNC
    } ppm_state_e;

    localparam int PPM_NUM_CH_DEF    = 6;
    localparam int PPM_GAP_CYC_DEF   = 40000;     // 0.4 ms at 100 MHz
    localparam int PPM_CNT_W_DEF     = 32;
    localparam int PPM_FRAME_LEN_DEF = 2000000;   // 20 ms at 100 MHz

endpackage

// File: rtl/ppm_seg_timer.sv
// Loadable down-counter timing one PPM segment; done is high on the final cycle of a
// loaded segment, so a load of N-1 yields a segment of exactly N cycles.
module ppm_seg_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - CNT_W'(1);
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/ppm_frame_sched.sv
// PPM frame scheduler: emits NUM_CH low-gap/high-channel pulses, a tail gap and a sync
// high stretching each frame to frame_len, from a shadow config loaded only between frames.
module ppm_frame_sched
    import ppm_pkg::*;
#(
    parameter int NUM_CH  = PPM_NUM_CH_DEF,
    parameter int GAP_CYC = PPM_GAP_CYC_DEF,
    parameter int CNT_W   = PPM_CNT_W_DEF
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         enable,
    input  logic [NUM_CH*CNT_W-1:0]      ch_width,
    input  logic [CNT_W-1:0]             frame_len,
    input  logic                         cfg_valid,
    output logic                         cfg_ack,
    output logic                         ppm_out,
    output logic [$clog2(NUM_CH+1)-1:0]  cur_ch,
    output logic                         frame_start,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int               CH_W     = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_W    = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    ppm_state_e       state;
    logic [CNT_W-1:0] sh_width [NUM_CH];
    logic [CNT_W-1:0] sh_frame_len;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] cur_w;
    logic [CNT_W-1:0] chan_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_load;
    logic             seg_done;
    logic             ack_q;
    logic             sync_exit;
    logic             start_frame;
    logic             overrun_set;

    always_comb begin
        cur_w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch == CH_W'(k)) cur_w = sh_width[k];
        end
    end

    // High time is width minus the gap, never shorter than one cycle.
    assign chan_load = (cur_w <= GAP_W) ? '0 : cur_w - GAP_W - ONE;

    // A zero frame_len can never be met, so it behaves as an immediate overrun.
    assign sync_exit   = (state == ST_SYNC) &&
                         ((sh_frame_len == '0) || (fcnt >= sh_frame_len - ONE));
    assign overrun_set = (state == ST_SYNC) && (fcnt >= sh_frame_len);
    assign start_frame = enable && ((state == ST_IDLE) || sync_exit);
    assign cfg_ack     = ARESETN && cfg_valid && !ack_q && ((state == ST_IDLE) || sync_exit);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        if (start_frame) begin
            tmr_load = 1'b1;
        end else if (state == ST_GAP && seg_done) begin
            tmr_load = 1'b1;
            tmr_val  = chan_load;
        end else if (state == ST_CHAN && seg_done) begin
            tmr_load = 1'b1;
        end
    end

    ppm_seg_timer #(.CNT_W(CNT_W)) u_seg_timer (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (seg_done)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sh_frame_len <= '0;
            for (int k = 0; k < NUM_CH; k++) sh_width[k] <= '0;
        end else if (cfg_ack) begin
            sh_frame_len <= frame_len;
            for (int k = 0; k < NUM_CH; k++) sh_width[k] <= ch_width[k*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            cur_ch      <= '0;
            fcnt        <= '0;
            ppm_out     <= 1'b1;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            ack_q       <= cfg_ack;
            overrun     <= overrun_set | (overrun & ~overrun_clr);
            if (state != ST_IDLE && fcnt != '1) fcnt <= fcnt + ONE;
            if (start_frame) begin
                state       <= ST_GAP;
                cur_ch      <= '0;
                fcnt        <= '0;
                frame_start <= 1'b1;
                ppm_out     <= 1'b0;
                busy        <= 1'b1;
            end else begin
                case (state)
                    ST_GAP: if (seg_done) begin
                        state   <= ST_CHAN;
                        ppm_out <= 1'b1;
                    end
                    ST_CHAN: if (seg_done) begin
                        ppm_out <= 1'b0;
                        if (cur_ch == LAST_CH) begin
                            state  <= ST_TAIL_GAP;
                            cur_ch <= CH_W'(NUM_CH);
                        end else begin
                            state  <= ST_GAP;
                            cur_ch <= cur_ch + CH_W'(1);
                        end
                    end
                    ST_TAIL_GAP: if (seg_done) begin
                        state   <= ST_SYNC;
                        ppm_out <= 1'b1;
                    end
                    ST_SYNC: if (sync_exit) begin
                        state  <= ST_IDLE;
                        cur_ch <= '0;
                        busy   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppm_frame_sched.sv
// Bench for ppm_frame_sched: table vectors, random frames against a waveform-list
// model, and hand sequences for mid-frame config, enable drop, overrun and reset.
module tb_ppm_frame_sched;

    localparam int NC  = 2;
    localparam int GAP = 4;
    localparam int CW  = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              enable = 1'b0;
    logic [NC*CW-1:0]  ch_width = '0;
    logic [CW-1:0]     frame_len = '0;
    logic              cfg_valid = 1'b0;
    logic              overrun_clr = 1'b0;
    logic              cfg_ack, ppm_out, frame_start, busy, overrun;
    logic [1:0]        cur_ch;

    int checks = 0;
    int failures = 0;

    bit exp_ppm[$];
    int exp_ch[$];

    typedef struct {
        int w0;
        int w1;
        int fl;
        int period;
        bit ovr;
    } vec_t;
    vec_t vecs[6];

    ppm_frame_sched #(.NUM_CH(NC), .GAP_CYC(GAP), .CNT_W(CW)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .ch_width    (ch_width),
        .frame_len   (frame_len),
        .cfg_valid   (cfg_valid),
        .cfg_ack     (cfg_ack),
        .ppm_out     (ppm_out),
        .cur_ch      (cur_ch),
        .frame_start (frame_start),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected frame as a list of (level, channel) per cycle, from the frame rules.
    task automatic build_frame(input int w0, input int w1, input int fl,
                               output int period, output bit ovr);
        int ws[NC];
        int n;
        ws[0] = w0;
        ws[1] = w1;
        exp_ppm.delete();
        exp_ch.delete();
        for (int k = 0; k < NC; k++) begin
            repeat (GAP) begin exp_ppm.push_back(1'b0); exp_ch.push_back(k); end
            repeat (((ws[k] > GAP) ? ws[k] : GAP + 1) - GAP) begin
                exp_ppm.push_back(1'b1); exp_ch.push_back(k);
            end
        end
        repeat (GAP) begin exp_ppm.push_back(1'b0); exp_ch.push_back(NC); end
        n = exp_ppm.size();
        ovr = (n >= fl);
        repeat (ovr ? 1 : fl - n) begin exp_ppm.push_back(1'b1); exp_ch.push_back(NC); end
        period = exp_ppm.size();
    endtask

    task automatic do_cfg(input int w0, input int w1, input int fl);
        int n = 0;
        ch_width  = {CW'(w1), CW'(w0)};
        frame_len = CW'(fl);
        cfg_valid = 1'b1;
        while (!cfg_ack && n < 100) begin tick(); n++; end
        check("cfg_ack_seen", cfg_ack, 1);
        tick();
        check("cfg_ack_single", cfg_ack, 0);
        cfg_valid = 1'b0;
    endtask

    task automatic start_frame(input bit keep);
        int n = 0;
        enable = 1'b1;
        while (!frame_start && n < 50) begin tick(); n++; end
        check("frame_start_seen", frame_start, 1);
        if (!keep) enable = 1'b0;
    endtask

    // Starts on a frame_start cycle; ends at the next frame_start or once busy drops.
    task automatic run_frame(input string tag, input int exp_period);
        int n = 0;
        int bad = 0;
        while ((n == 0 || !frame_start) && busy && n < 400) begin
            if (n >= exp_ppm.size()) bad++;
            else if (ppm_out !== exp_ppm[n] || cur_ch !== 2'(exp_ch[n]) ||
                     frame_start !== (n == 0) || cfg_ack !== 1'b0) bad++;
            n++;
            tick();
        end
        check({tag, "_period"}, n, exp_period);
        check({tag, "_wave"}, bad, 0);
    endtask

    task automatic clr_overrun();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
    endtask

    initial begin
        int p;
        bit ovr;
        int ack_n;
        int bad;
        int w0, w1, fl;

        vecs[0] = '{10, 12, 40, 40, 1'b0};
        vecs[1] = '{ 2, 12, 40, 40, 1'b0};
        vecs[2] = '{20, 20, 30, 45, 1'b1};
        vecs[3] = '{10, 12, 26, 27, 1'b1};
        vecs[4] = '{10, 12, 27, 27, 1'b0};
        vecs[5] = '{ 0,  0,  0, 15, 1'b1};

        cfg_valid = 1'b1;
        repeat (3) tick();
        check("rst_ppm_out", ppm_out, 1);
        check("rst_busy", busy, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cur_ch", cur_ch, 0);
        cfg_valid = 1'b0;
        ARESETN = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            clr_overrun();
            do_cfg(vecs[i].w0, vecs[i].w1, vecs[i].fl);
            build_frame(vecs[i].w0, vecs[i].w1, vecs[i].fl, p, ovr);
            start_frame(1'b0);
            run_frame($sformatf("vec%0d", i), vecs[i].period);
            check($sformatf("vec%0d_overrun", i), overrun, vecs[i].ovr);
            check($sformatf("vec%0d_idle_ppm", i), ppm_out, 1);
            check($sformatf("vec%0d_idle_busy", i), busy, 0);
        end

        for (int i = 0; i < 8; i++) begin
            w0 = $urandom_range(0, 30);
            w1 = $urandom_range(0, 30);
            fl = $urandom_range(0, 90);
            clr_overrun();
            do_cfg(w0, w1, fl);
            build_frame(w0, w1, fl, p, ovr);
            start_frame(1'b0);
            run_frame($sformatf("rnd%0d", i), p);
            check($sformatf("rnd%0d_overrun", i), overrun, ovr);
        end

        // Two back-to-back frames, enable dropped during the second.
        clr_overrun();
        do_cfg(10, 12, 40);
        build_frame(10, 12, 40, p, ovr);
        start_frame(1'b1);
        run_frame("rep1", 40);
        enable = 1'b0;
        run_frame("rep2", 40);
        check("rep_idle_busy", busy, 0);

        // New config mid-frame: must not disturb the running frame, acked at SYNC exit.
        start_frame(1'b1);
        ack_n = -1;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (n == 5) begin
                ch_width  = {CW'(8), CW'(6)};
                frame_len = CW'(30);
                cfg_valid = 1'b1;
            end
            if (ppm_out !== exp_ppm[n] || cur_ch !== 2'(exp_ch[n])) bad++;
            if (cfg_ack && ack_n < 0) ack_n = n;
            tick();
        end
        check("midcfg_old_wave", bad, 0);
        check("midcfg_ack_cycle", ack_n, 39);
        check("midcfg_next_start", frame_start, 1);
        cfg_valid = 1'b0;
        enable = 1'b0;
        build_frame(6, 8, 30, p, ovr);
        run_frame("midcfg_new", p);

        // Clear held through an overrunning frame: the new overrun still sets.
        overrun_clr = 1'b1;
        do_cfg(20, 20, 30);
        start_frame(1'b0);
        repeat (45) tick();
        check("ovr_set_wins", overrun, 1);
        tick();
        check("ovr_clr", overrun, 0);
        overrun_clr = 1'b0;

        // Reset during CHAN of channel 0.
        do_cfg(10, 12, 40);
        start_frame(1'b0);
        repeat (6) tick();
        check("pre_rst_ppm_high_chan", ppm_out, 1);
        ARESETN = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_ppm", ppm_out, 1);
        check("async_rst_cur_ch", cur_ch, 0);
        repeat (2) tick();
        ARESETN = 1'b1;
        repeat (3) tick();
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_ppm", ppm_out, 1);
        build_frame(0, 0, 0, p, ovr);
        start_frame(1'b0);
        run_frame("post_rst_min", 15);
        do_cfg(10, 12, 40);
        build_frame(10, 12, 40, p, ovr);
        start_frame(1'b0);
        run_frame("post_rst_cfg", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
